// File: rtl/scoreboard_input_conditioner.sv
// Conditions the three active-low scoreboard buttons into increment pulses and a reset-hold event.
// Optional auto-repeat of held increment buttons: define SCOREBOARD_AUTO_REPEAT_EN.
module scoreboard_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 100000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic inc1_btn_n,
  input  logic inc10_btn_n,
  input  logic reset_btn_n,
  output logic inc1_pulse,
  output logic inc10_pulse,
  output logic reset_ready,
  output logic reset_held
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LIMIT  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic {INC_IDLE, INC_PRESSED} inc_state_t;
  typedef enum logic [1:0] {RST_IDLE, RST_HOLDING, RST_FIRED} rst_state_t;

  // Bit order everywhere: [0]=INC1, [1]=INC10, [2]=RESET
  logic [2:0]      w_raw_n;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      w_level;
  logic [2:0]      r_acc;
  logic [DB_W-1:0] r_db_cnt [3];
  logic            w_acc_reset;

  assign w_raw_n     = {reset_btn_n, inc10_btn_n, inc1_btn_n};
  assign w_level     = ~r_sync2;
  assign w_acc_reset = r_acc[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw_n;
      r_sync2 <= r_sync1;
    end
  end

  // A full count toggles regardless of the current sample; any agreement before that restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      for (int unsigned i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_db_cnt[i] == DB_LIMIT) begin
          r_acc[i]    <= ~r_acc[i];
          r_db_cnt[i] <= '0;
        end else if (w_level[i] != r_acc[i]) begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  inc_state_t r_inc_state [2];
  inc_state_t w_inc_next  [2];
  logic [1:0] w_inc_fire;
  logic [1:0] w_rep_hit;

`ifdef SCOREBOARD_AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] r_rep_cnt [2];
  logic [1:0]       r_rep_first;

  always_comb begin
    w_rep_hit = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      w_rep_hit[i] = (r_inc_state[i] == INC_PRESSED) && r_acc[i] && !w_acc_reset &&
                     (r_rep_cnt[i] == (r_rep_first[i] ? REP_DLY_LAST : REP_PER_LAST));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_first <= '1;
      for (int unsigned i = 0; i < 2; i++) r_rep_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_inc_state[i] != INC_PRESSED) begin
          r_rep_cnt[i]   <= '0;
          r_rep_first[i] <= 1'b1;
        end else if (w_acc_reset) begin
          r_rep_cnt[i] <= '0;
        end else if (w_rep_hit[i]) begin
          r_rep_cnt[i]   <= '0;
          r_rep_first[i] <= 1'b0;
        end else begin
          r_rep_cnt[i] <= r_rep_cnt[i] + REP_W'(1);
        end
      end
    end
  end
`else
  assign w_rep_hit = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) r_inc_state[i] <= INC_IDLE;
    end else begin
      for (int unsigned i = 0; i < 2; i++) r_inc_state[i] <= w_inc_next[i];
    end
  end

  always_comb begin
    w_inc_fire = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      w_inc_next[i] = r_inc_state[i];
      case (r_inc_state[i])
        INC_IDLE: begin
          if (r_acc[i]) begin
            w_inc_next[i] = INC_PRESSED;
            w_inc_fire[i] = 1'b1;
          end
        end
        INC_PRESSED: begin
          if (!r_acc[i]) w_inc_next[i] = INC_IDLE;
          else if (w_rep_hit[i]) w_inc_fire[i] = 1'b1;
        end
        default: w_inc_next[i] = INC_IDLE;
      endcase
    end
  end

  rst_state_t        r_rst_state;
  rst_state_t        w_rst_next;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              w_hold_clr;
  logic              w_hold_inc;
  logic              w_ready_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_state <= RST_IDLE;
      r_hold_cnt  <= '0;
    end else begin
      r_rst_state <= w_rst_next;
      if (w_hold_clr)      r_hold_cnt <= '0;
      else if (w_hold_inc) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
    end
  end

  always_comb begin
    w_rst_next   = r_rst_state;
    w_hold_clr   = 1'b0;
    w_hold_inc   = 1'b0;
    w_ready_fire = 1'b0;
    case (r_rst_state)
      RST_IDLE: begin
        if (w_acc_reset) begin
          w_rst_next = RST_HOLDING;
          w_hold_clr = 1'b1;
        end
      end
      RST_HOLDING: begin
        if (!w_acc_reset) begin
          w_rst_next = RST_IDLE;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_rst_next   = RST_FIRED;
          w_ready_fire = 1'b1;
        end else begin
          w_hold_inc = 1'b1;
        end
      end
      RST_FIRED: begin
        if (!w_acc_reset) w_rst_next = RST_IDLE;
      end
      default: w_rst_next = RST_IDLE;
    endcase
  end

  // Gating uses the same value reset_held takes this edge, so masking lines up cycle-exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc1_pulse  <= 1'b0;
      inc10_pulse <= 1'b0;
      reset_ready <= 1'b0;
      reset_held  <= 1'b0;
    end else begin
      inc1_pulse  <= w_inc_fire[0] & ~w_acc_reset;
      inc10_pulse <= w_inc_fire[1] & ~w_acc_reset;
      reset_ready <= w_ready_fire;
      reset_held  <= w_acc_reset;
    end
  end

endmodule

// File: tb/tb_scoreboard_input_conditioner.sv
// Directed bench for scoreboard_input_conditioner with an edge-indexed reference model.
module tb_scoreboard_input_conditioner;
  localparam int N    = 4;
  localparam int H    = 20;
  localparam int RD   = 10;
  localparam int RP   = 5;
  localparam int MAXE = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inc1_n = 1'b1, inc10_n = 1'b1, reset_n = 1'b1;
  logic inc1_pulse, inc10_pulse, reset_ready, reset_held;

  scoreboard_input_conditioner #(
    .DEBOUNCE_CYCLES(N), .HOLD_CYCLES(H), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst),
    .inc1_btn_n(inc1_n), .inc10_btn_n(inc10_n), .reset_btn_n(reset_n),
    .inc1_pulse(inc1_pulse), .inc10_pulse(inc10_pulse),
    .reset_ready(reset_ready), .reset_held(reset_held)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, indexed by rising-edge number e (after edge e the DUT outputs are exp_*[e]).
  int e    = 0;
  int base = 0;
  bit lvl [3][MAXE];
  bit acc [3][MAXE];
  int last_flip [3];
  int press_edge [2];
  bit exp_p [2][MAXE];
  bit exp_rdy  [MAXE];
  bit exp_held [MAXE];

  function automatic bit g_lvl(int b, int j);
    if (j < 0 || j < base) return 1'b0;
    return lvl[b][j];
  endfunction

  function automatic bit g_acc(int b, int j);
    if (j < 0) return 1'b0;
    return acc[b][j];
  endfunction

  function automatic bit g_held(int j);
    if (j < 0) return 1'b0;
    return exp_held[j];
  endfunction

  always @(posedge clk) begin : model
    bit prev, flip, rise, rep, ok;
    int d;
    if (e >= MAXE) begin
      $display("FAIL model_capacity: edge %0d reached limit %0d", e, MAXE);
      n_fail++;
      $fatal(1, "model capacity exceeded");
    end
    if (rst) begin
      base = e + 1;
      for (int b = 0; b < 3; b++) begin
        lvl[b][e] = 1'b0; acc[b][e] = 1'b0; last_flip[b] = e;
      end
      for (int b = 0; b < 2; b++) begin
        press_edge[b] = -1; exp_p[b][e] = 1'b0;
      end
      exp_rdy[e] = 1'b0; exp_held[e] = 1'b0;
    end else begin
      lvl[0][e] = !inc1_n; lvl[1][e] = !inc10_n; lvl[2][e] = !reset_n;
      // Accepted level flips once N consecutive synchronized samples (2 edges late) disagree with it.
      for (int b = 0; b < 3; b++) begin
        prev = g_acc(b, e - 1);
        flip = (e - N > last_flip[b]);
        for (int j = e - N - 2; j <= e - 3; j++) if (g_lvl(b, j) == prev) flip = 1'b0;
        acc[b][e] = flip ? !prev : prev;
        if (flip) last_flip[b] = e;
      end
      exp_held[e] = g_acc(2, e - 1);
      for (int b = 0; b < 2; b++) begin
        rise = g_acc(b, e - 1) && !g_acc(b, e - 2);
        if (rise) press_edge[b] = e;
        rep = 1'b0;
`ifdef SCOREBOARD_AUTO_REPEAT_EN
        if (!rise && press_edge[b] >= 0) begin
          ok = 1'b1;
          for (int j = press_edge[b] - 1; j <= e - 1; j++) if (!g_acc(b, j)) ok = 1'b0;
          for (int j = press_edge[b]; j <= e; j++) if (g_held(j)) ok = 1'b0;
          d = e - press_edge[b];
          if (ok && d >= RD && ((d - RD) % RP) == 0) rep = 1'b1;
        end
`endif
        exp_p[b][e] = (rise || rep) && !exp_held[e];
      end
      ok = !g_held(e - H - 1);
      for (int j = e - H; j <= e; j++) if (!g_held(j)) ok = 1'b0;
      exp_rdy[e] = ok;
    end
    e++;
  end

  task automatic chk(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %b, expected %b", name, e - 1, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Observed event log for the hand-computed checks.
  int q1 [$];
  int q10 [$];
  int qr [$];
  int held_rise = -1;
  logic prev_held = 1'b0;

  always @(negedge clk) begin : compare
    int k;
    if (e > 0) begin
      k = e - 1;
      chk("inc1_pulse", inc1_pulse, exp_p[0][k]);
      chk("inc10_pulse", inc10_pulse, exp_p[1][k]);
      chk("reset_ready", reset_ready, exp_rdy[k]);
      chk("reset_held", reset_held, exp_held[k]);
      if (inc1_pulse === 1'b1)  q1.push_back(k);
      if (inc10_pulse === 1'b1) q10.push_back(k);
      if (reset_ready === 1'b1) qr.push_back(k);
      if (reset_held === 1'b1 && prev_held !== 1'b1) held_rise = k;
      prev_held = reset_held;
    end
  end

  // Waits n falling edges, then settles past the compare process before driving or checking.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    q1.delete(); q10.delete(); qr.delete(); held_rise = -1;
  endtask

  int t0;
  int exp_n;

  initial begin
    step(3);
    rst = 1'b0;
    step(5);
    chk_int("reset_state_outputs", {inc1_pulse, inc10_pulse, reset_ready, reset_held}, 0);

    // Clean INC1 press held 30 cycles
    clear_logs(); t0 = e; inc1_n = 1'b0;
    step(30); inc1_n = 1'b1; step(15);
`ifdef SCOREBOARD_AUTO_REPEAT_EN
    exp_n = 5;
`else
    exp_n = 1;
`endif
    chk_int("inc1_clean_count", q1.size(), exp_n);
    chk_int("inc1_clean_latency", (q1.size() > 0) ? q1[0] - t0 : -1, 7);
    chk_int("inc1_clean_no_inc10", q10.size(), 0);

    // INC10 bounce, then a steady low of 10 cycles
    clear_logs();
    inc10_n = 1'b0; step(2); inc10_n = 1'b1; step(1);
    inc10_n = 1'b0; step(3); inc10_n = 1'b1; step(1);
    t0 = e; inc10_n = 1'b0; step(10); inc10_n = 1'b1; step(15);
    chk_int("inc10_bounce_count", q10.size(), 1);
    chk_int("inc10_bounce_latency", (q10.size() > 0) ? q10[0] - t0 : -1, 7);

    // RESET held 40 cycles
    clear_logs(); t0 = e; reset_n = 1'b0;
    step(40); reset_n = 1'b1; step(15);
    chk_int("reset_held_rise", held_rise - t0, 7);
    chk_int("reset_ready_count", qr.size(), 1);
    chk_int("reset_ready_latency", (qr.size() > 0) ? qr[0] - t0 : -1, 27);

    // RESET held only 15 cycles
    clear_logs(); reset_n = 1'b0;
    step(15); reset_n = 1'b1; step(30);
    chk_int("reset_short_no_ready", qr.size(), 0);

    // INC1 pressed while reset_held, RESET released first
    clear_logs(); reset_n = 1'b0; step(10);
    chk_int("reset_held_level", reset_held, 1);
    inc1_n = 1'b0; step(10); reset_n = 1'b1; step(3); inc1_n = 1'b1; step(20);
    chk_int("inc1_consumed_under_reset", q1.size(), 0);

    // INC1 and INC10 pressed on the same edge
    clear_logs(); t0 = e; inc1_n = 1'b0; inc10_n = 1'b0;
    step(10); inc1_n = 1'b1; inc10_n = 1'b1; step(15);
    chk_int("dual_inc1_latency", (q1.size() == 1) ? q1[0] - t0 : -1, 7);
    chk_int("dual_inc10_latency", (q10.size() == 1) ? q10[0] - t0 : -1, 7);

    // rst while INC1 PRESSED and reset_held high; INC1 stays held through rst
    clear_logs(); inc1_n = 1'b0; step(10); reset_n = 1'b0; step(10);
    rst = 1'b1; #1;
    chk_int("rst_clears_outputs", {inc1_pulse, inc10_pulse, reset_ready, reset_held}, 0);
    reset_n = 1'b1;
    step(3); rst = 1'b0; t0 = e; clear_logs();
    step(10); inc1_n = 1'b1; step(15);
    chk_int("inc1_after_rst_count", q1.size(), 1);
    chk_int("inc1_after_rst_latency", (q1.size() > 0) ? q1[0] - t0 : -1, 7);

    // INC1 held 35 cycles: press pulse plus any auto-repeats
    clear_logs(); t0 = e; inc1_n = 1'b0;
    step(35); inc1_n = 1'b1; step(20);
`ifdef SCOREBOARD_AUTO_REPEAT_EN
    chk_int("repeat_count", q1.size(), 6);
    if (q1.size() == 6) begin
      chk_int("repeat_0", q1[0] - t0, 7);
      chk_int("repeat_1", q1[1] - t0, 17);
      chk_int("repeat_2", q1[2] - t0, 22);
      chk_int("repeat_5", q1[5] - t0, 37);
    end
`else
    chk_int("single_pulse_count", q1.size(), 1);
    chk_int("single_pulse_latency", (q1.size() > 0) ? q1[0] - t0 : -1, 7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
